// File: rtl/fpu_norm_pkg.sv
// Shared definitions for the FPU add/sub normalization controller.
package fpu_norm_pkg;

    typedef enum logic [1:0] {StIdle, StScan, StDone} norm_state_e;

    localparam int unsigned DefChunk = 4;

    // Must match the barrel shifter's left/right select encoding.
    localparam logic SHIFT_LEFT  = 1'b1;
    localparam logic SHIFT_RIGHT = 1'b0;

    function automatic int unsigned num_chunks(input int unsigned width, input int unsigned chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/chunk_lead_one.sv
// Combinational priority encoder: offset of the highest set bit, counted from the chunk MSB.
module chunk_lead_one
    import fpu_norm_pkg::*;
#(
    parameter int unsigned Chunk = DefChunk,
    parameter int unsigned OffW  = (Chunk > 1) ? $clog2(Chunk) : 1
) (
    input  logic [Chunk-1:0] chunk_i,
    output logic             found_o,
    output logic [OffW-1:0]  offset_o
);

    always_comb begin
        found_o  = |chunk_i;
        offset_o = '0;
        // Scanning upward lets the highest set bit win.
        for (int i = 0; i < Chunk; i++) begin
            if (chunk_i[i]) begin
                offset_o = OffW'(Chunk - 1 - i);
            end
        end
    end

endmodule

// File: rtl/norm_shift_ctrl.sv
// Sequential leading-one scan that produces shift controls and the normalized exponent.
module norm_shift_ctrl
    import fpu_norm_pkg::*;
#(
    parameter int unsigned SWR   = 26,
    parameter int unsigned EWR   = 8,
    parameter int unsigned CHUNK = DefChunk
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [SWR:0]   Add_Result_i,
    input  logic [EWR-1:0] Exp_i,
    output logic           busy_o,
    output logic           ready_o,
    output logic [EWR-1:0] Shift_Value_o,
    output logic           Left_Right_o,
    output logic           Bit_Shift_o,
    output logic [EWR-1:0] Exp_o,
    output logic           Zero_o,
    output logic           Underflow_o,
    output logic           Overflow_o
);

    localparam int unsigned Nch  = num_chunks(SWR, CHUNK);
    localparam int unsigned PadW = Nch * CHUNK - SWR;
    localparam int unsigned CntW = (Nch > 1) ? $clog2(Nch) : 1;
    localparam int unsigned OffW = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    norm_state_e    state_q;
    logic [SWR:0]   res_q;
    logic [EWR-1:0] exp_q;
    logic [CntW-1:0] cnt_q;

    logic           busy_q, ready_q, lr_q, bs_q, zero_q, uf_q, of_q;
    logic [EWR-1:0] shamt_q, expo_q;

    logic [Nch*CHUNK-1:0] sig_pad, sig_sh;
    logic [CHUNK-1:0]     chunk;
    logic                 found;
    logic [OffW-1:0]      offset;

    generate
        if (PadW == 0) begin : g_nopad
            assign sig_pad = res_q[SWR-1:0];
        end else begin : g_pad
            assign sig_pad = {res_q[SWR-1:0], {PadW{1'b0}}};
        end
    endgenerate

    // Bring chunk k to the top so the encoder always sees a fixed slice.
    assign sig_sh = sig_pad << (32'(cnt_q) * CHUNK);
    assign chunk  = sig_sh[Nch*CHUNK-1 -: CHUNK];

    chunk_lead_one #(
        .Chunk(CHUNK),
        .OffW (OffW)
    ) u_lead_one (
        .chunk_i (chunk),
        .found_o (found),
        .offset_o(offset)
    );

    logic [EWR:0] exp_ext, exp_inc, exp_max, exp_sub, lz;
    logic         carry_ovf, lz_uf;

    always_comb begin
        exp_ext   = {1'b0, exp_q};
        exp_max   = {1'b0, {EWR{1'b1}}};
        exp_inc   = exp_ext + (EWR + 1)'(1);
        lz        = (EWR + 1)'(cnt_q) * (EWR + 1)'(CHUNK) + (EWR + 1)'(offset);
        exp_sub   = exp_ext - lz;
        carry_ovf = exp_inc >= exp_max;
        lz_uf     = lz >= exp_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            res_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            shamt_q <= '0;
            lr_q    <= 1'b0;
            bs_q    <= 1'b0;
            expo_q  <= '0;
            zero_q  <= 1'b0;
            uf_q    <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        res_q   <= Add_Result_i;
                        exp_q   <= Exp_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StScan;
                    end
                end
                StScan: begin
                    if (cnt_q == '0 && res_q[SWR]) begin
                        lr_q    <= SHIFT_RIGHT;
                        shamt_q <= EWR'(1);
                        bs_q    <= 1'b1;
                        expo_q  <= carry_ovf ? exp_max[EWR-1:0] : exp_inc[EWR-1:0];
                        of_q    <= carry_ovf;
                        uf_q    <= 1'b0;
                        zero_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= StDone;
                    end else if (found) begin
                        lr_q    <= SHIFT_LEFT;
                        bs_q    <= 1'b0;
                        shamt_q <= lz_uf ? exp_q : EWR'(lz);
                        expo_q  <= lz_uf ? '0 : exp_sub[EWR-1:0];
                        uf_q    <= lz_uf;
                        of_q    <= 1'b0;
                        zero_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= StDone;
                    end else if (cnt_q == CntW'(Nch - 1)) begin
                        lr_q    <= SHIFT_LEFT;
                        bs_q    <= 1'b0;
                        shamt_q <= '0;
                        expo_q  <= '0;
                        zero_q  <= 1'b1;
                        uf_q    <= 1'b0;
                        of_q    <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign ready_o       = ready_q;
    assign Shift_Value_o = shamt_q;
    assign Left_Right_o  = lr_q;
    assign Bit_Shift_o   = bs_q;
    assign Exp_o         = expo_q;
    assign Zero_o        = zero_q;
    assign Underflow_o   = uf_q;
    assign Overflow_o    = of_q;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Bench for norm_shift_ctrl: directed table, random vs. arithmetic model, busy and reset sequences.
module tb_norm_shift_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [26:0] Add_Result_i;
    logic [7:0]  Exp_i;
    logic        busy_o, ready_o, Left_Right_o, Bit_Shift_o, Zero_o, Underflow_o, Overflow_o;
    logic [7:0]  Shift_Value_o, Exp_o;

    int total;
    int bad;

    norm_shift_ctrl #(
        .SWR  (26),
        .EWR  (8),
        .CHUNK(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .Add_Result_i (Add_Result_i),
        .Exp_i        (Exp_i),
        .busy_o       (busy_o),
        .ready_o      (ready_o),
        .Shift_Value_o(Shift_Value_o),
        .Left_Right_o (Left_Right_o),
        .Bit_Shift_o  (Bit_Shift_o),
        .Exp_o        (Exp_o),
        .Zero_o       (Zero_o),
        .Underflow_o  (Underflow_o),
        .Overflow_o   (Overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] ar;
        logic [7:0]  ex;
        int lat, lr, sv, bs, eo, z, u, o;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string nm);
        int packed_outs;
        packed_outs = int'({busy_o, ready_o, Shift_Value_o, Left_Right_o, Bit_Shift_o, Exp_o,
                            Zero_o, Underflow_o, Overflow_o});
        check(nm, packed_outs, 0);
    endtask

    // Reference: locate the leading one with plain integer arithmetic.
    function automatic vec_t model(input logic [26:0] ar, input logic [7:0] ex);
        vec_t m;
        int p, lz, e;
        e = int'(ex);
        m.ar = ar; m.ex = ex;
        m.lr = 1; m.bs = 0; m.z = 0; m.u = 0; m.o = 0; m.sv = 0; m.eo = 0;
        p = -1;
        if (ar[26]) begin
            m.lat = 2; m.lr = 0; m.sv = 1; m.bs = 1;
            if (e + 1 >= 255) begin m.o = 1; m.eo = 255; end
            else m.eo = e + 1;
        end else begin
            for (int i = 0; i < 26; i++) if (ar[i]) p = i;
            if (p < 0) begin
                m.lat = 8; m.z = 1;
            end else begin
                lz = 25 - p;
                m.lat = lz / 4 + 2;
                if (lz < e) begin m.sv = lz; m.eo = e - lz; end
                else begin m.u = 1; m.sv = e; m.eo = 0; end
            end
        end
        return m;
    endfunction

    // icyc: cycle in which a stray start (iar/iex) is held high; 0 = none.
    task automatic run(input string tag, input vec_t v, input int icyc,
                       input logic [26:0] iar, input logic [7:0] iex);
        int lat;
        lat = 0;
        @(negedge clk);
        Add_Result_i = v.ar; Exp_i = v.ex; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        check({tag, " busy"}, int'(busy_o), 1);
        for (int c = 2; c <= 20 && lat == 0; c++) begin
            if (c - 1 == icyc) begin
                start_i = 1'b1; Add_Result_i = iar; Exp_i = iex;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            if (ready_o) lat = c;
        end
        check({tag, " latency"}, lat, v.lat);
        if (lat != 0) begin
            check({tag, " left_right"}, int'(Left_Right_o), v.lr);
            check({tag, " shift_value"}, int'(Shift_Value_o), v.sv);
            check({tag, " bit_shift"}, int'(Bit_Shift_o), v.bs);
            check({tag, " exp"}, int'(Exp_o), v.eo);
            check({tag, " flags"}, int'({Zero_o, Underflow_o, Overflow_o}),
                  v.z * 4 + v.u * 2 + v.o);
            @(posedge clk); #1;
            check({tag, " ready_pulse"}, int'({ready_o, busy_o}), 0);
        end
    endtask

    vec_t vecs[10];
    vec_t rv;
    int   seen;

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; start_i = 1'b0; Add_Result_i = '0; Exp_i = '0;

        //           ar            ex      lat lr sv bs eo  z u o
        vecs[0] = '{27'h4000000, 8'd127, 2, 0, 1, 1, 128, 0, 0, 0};
        vecs[1] = '{27'h2000000, 8'd127, 2, 1, 0, 0, 127, 0, 0, 0};
        vecs[2] = '{27'h0010000, 8'd127, 4, 1, 9, 0, 118, 0, 0, 0};
        vecs[3] = '{27'h0000000, 8'd127, 8, 1, 0, 0, 0,   1, 0, 0};
        vecs[4] = '{27'h0000001, 8'd10,  8, 1, 10, 0, 0,  0, 1, 0};
        vecs[5] = '{27'h4000000, 8'd254, 2, 0, 1, 1, 255, 0, 0, 1};
        vecs[6] = '{27'h4000000, 8'd255, 2, 0, 1, 1, 255, 0, 0, 1};
        vecs[7] = '{27'h0000010, 8'd30,  7, 1, 21, 0, 9,  0, 0, 0};
        vecs[8] = '{27'h7ffffff, 8'd0,   2, 0, 1, 1, 1,   0, 0, 0};
        vecs[9] = '{27'h2000000, 8'd0,   2, 1, 0, 0, 0,   0, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run($sformatf("vec%0d", i), vecs[i], 0, '0, '0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [26:0] r;
            r = 27'($urandom) >> $urandom_range(0, 27);
            if ($urandom_range(0, 4) == 0) r[26] = 1'b1;
            rv = model(r, 8'($urandom_range(0, 255)));
            run($sformatf("rnd%0d", i), rv, 0, '0, '0);
        end

        // Stray start during SCAN must not disturb the latched operands.
        run("busy_ignore", vecs[2], 2, 27'h4000000, 8'd5);

        // Reset mid-scan: outputs clear at once and no ready pulse follows.
        @(negedge clk);
        Add_Result_i = '0; Exp_i = 8'd50; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_zero("rst_mid_outputs");
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ready_o) seen = 1;
        end
        check("rst_mid_no_ready", seen, 0);
        run("post_reset", vecs[7], 0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
